sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
//  Upstream feeder for the SHA-256 core. Accepts a 32-bit word stream, packs it into 512-bit
//  blocks, appends FIPS 180-4 padding (0x80, zeros, 64-bit bit length) and drives the core's
//  init/next/block inputs with one block per core-ready window. Frees software from padding.
// PARAMETERS
//  LEN_W   64  width of message bit-length counter (4..64); zero-extended into block bits [63:0]
// PORTS
//  clk          in   1    single clock
//  rst_n        in   1    asynchronous, active-low reset
//  clear_i      in   1    sync abort: drop buffer/length, return to IDLE
//  in_valid_i   in   1    word valid
//  in_ready_o   out  1    word accepted when in_valid_i & in_ready_o
//  in_data_i    in   32   big-endian word; first byte in [31:24]
//  in_last_i    in   1    final word of message
//  in_bytes_i   in   3    valid bytes, 1..4; 0 legal only with in_last_i (zero-length word)
//  core_ready_i in   1    core ready
//  core_init_o  out  1    1-cycle pulse: first block of message
//  core_next_o  out  1    1-cycle pulse: subsequent block
//  core_block_o out  512  block; word 0 in [511:480], word 15 in [31:0]
//  done_o       out  1    1-cycle pulse: final block complete (core ready again)
//  busy_o       out  1    high outside IDLE/FILL-empty
// BEHAVIOUR
//  Reset: in_ready_o=0, core_init_o=0, core_next_o=0, core_block_o=0, done_o=0, busy_o=0;
//    counters zero, FSM=IDLE. Reset mid-operation abandons the message; core is not touched.
//  States: IDLE -> FILL on reset release (1 cycle). FILL: in_ready_o=1; each accepted word
//    writes word[wcnt], wcnt++, len += 8*in_bytes_i (wraps mod 2^LEN_W).
//  Non-last word with wcnt reaching 16 -> ISSUE (more=1).
//  Last word: bytes beyond in_bytes_i replaced by 0x80 then zeros; if in_bytes_i=4, 0x80
//    goes at start of next word (pad_pending). in_bytes_i=0: word itself becomes 0x80000000.
//    Words used U (incl. 0x80 word): U<=14 -> zero words to 13, len in words 14-15, ISSUE(final);
//    U>14 -> zero remainder, ISSUE(more), then LENBLK.
//  LENBLK (1 cycle): block = {pad_pending?0x80000000:0, zeros, len}; ISSUE(final).
//  ISSUE: wait core_ready_i=1; pulse core_init_o if first block of message else core_next_o;
//    core_block_o updated same cycle as pulse, stable until next pulse. -> HOLD.
//  HOLD (1 cycle, core drops ready) -> WAIT. WAIT: core_ready_i=1 -> FILL with wcnt=0 (more)
//    or -> done_o pulse, clear len/first flag, -> FILL (final).
//  in_ready_o=0 in every state except FILL; no word accepted during ISSUE/HOLD/WAIT/LENBLK.
//  Throughput: 1 word/cycle into buffer; block issue latency 1 cycle after core ready.
//  clear_i has priority over all inputs; pulses suppressed that cycle.
//  Simultaneous in_valid_i & clear_i: word dropped.
//  in_bytes_i=0 without in_last_i, or >4: word accepted, treated as 4 bytes (not asserted).
// CONFIGURATION
//  SHA256_PADDER_BSWAP_EN defined: in_data_i byte-reversed on entry (first byte in [7:0],
//    partial last word uses low bytes) for little-endian masters.
//  Undefined: in_data_i used as-is, big-endian.
//  Padding/length always big-endian.
// TESTING
//  "abc": one word 0x61626300, last, bytes=3 -> block w0=0x61626380, w1-14=0, w15=0x18,
//    core_init_o once; digest ba7816bf...f20015ad.
//  Empty: last, bytes=0 -> w0=0x80000000, rest 0; digest e3b0c442...7852b855.
//  56-byte "abcdbcde...nopq" -> two blocks: second w0-13=0, w15=0x1C0 via LENBLK,
//    init then next; digest 248d6a61...19db06c1.
//  64 bytes full -> second block w0=0x80000000, w15=0x200, core_next_o on second.
//  Backpressure: hold core_ready_i=0 for 20 cycles after pulse -> in_ready_o=0 throughout,
//    no word lost, resumes 1 cycle after core ready.
//  rst_n low during WAIT -> all outputs 0 immediately; next "abc" uses core_init_o.
//  clear_i mid-FILL -> next "abc" gives correct digest.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a 32-bit word stream into 512-bit blocks,
// appends the 0x80 / zero / 64-bit-length padding and hands each block to the
// core through an init/next pulse, one block per core-ready window.
// Optional build macro: SHA256_PADDER_BSWAP_EN (byte-reverse in_data_i for
// little-endian masters; padding and length stay big-endian).
module sha256_msg_padder #(
   parameter int unsigned LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [31:0]  in_data_i,
   input  logic         in_last_i,
   input  logic [2:0]   in_bytes_i,
   input  logic         core_ready_i,
   output logic         core_init_o,
   output logic         core_next_o,
   output logic [511:0] core_block_o,
   output logic         done_o,
   output logic         busy_o
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned NWORDS = 16;
   localparam int unsigned BLK_W  = 512;
   localparam int unsigned WCNT_W = 5;
   localparam int unsigned USED_W = 6;

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_ISSUE, S_HOLD, S_WAIT, S_LENBLK
   } state_e;

   // word k of the block lives in buf_q[15-k] so that word 0 lands in [511:480]
   state_e                           state_q, state_d;
   logic [NWORDS-1:0][WORD_W-1:0]    buf_q, buf_d;
   logic [WCNT_W-1:0]                wcnt_q, wcnt_d;
   logic [LEN_W-1:0]                 len_q, len_d;
   logic                             first_q, first_d;
   logic                             more_q, more_d;
   logic                             lenblk_q, lenblk_d;
   logic                             pad_q, pad_d;
   logic [BLK_W-1:0]                 block_q, block_d;
   logic                             init_q, init_d;
   logic                             next_q, next_d;
   logic                             done_q, done_d;
   logic                             in_ready_q, in_ready_d;
   logic                             busy_q, busy_d;

   logic [WORD_W-1:0]                word_in;
   logic [2:0]                       beff;
   logic [WORD_W-1:0]                last_word;
   logic [LEN_W-1:0]                 len_acc;
   logic [63:0]                      len_ext_acc;
   logic [63:0]                      len_ext_q;
   logic                             pad4;
   logic [USED_W-1:0]                used;

   // Incoming word shaping: byte order, effective byte count, 0x80 insertion
   always_comb begin
`ifdef SHA256_PADDER_BSWAP_EN
      word_in = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
      word_in = in_data_i;
`endif
      if (in_last_i && (in_bytes_i == 3'd0)) begin
         beff = 3'd0;
      end else if ((in_bytes_i == 3'd0) || (in_bytes_i > 3'd4)) begin
         beff = 3'd4;
      end else begin
         beff = in_bytes_i;
      end
      case (beff)
         3'd0:    last_word = 32'h8000_0000;
         3'd1:    last_word = {word_in[31:24], 8'h80, 16'h0000};
         3'd2:    last_word = {word_in[31:16], 8'h80, 8'h00};
         3'd3:    last_word = {word_in[31:8], 8'h80};
         default: last_word = word_in;
      endcase
      len_acc     = len_q + LEN_W'({beff, 3'b000});
      len_ext_acc = 64'(len_acc);
      len_ext_q   = 64'(len_q);
      pad4        = (beff == 3'd4);
      used        = USED_W'(wcnt_q) + USED_W'(1) + USED_W'(pad4);
   end

   // Next-state and output logic
   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      wcnt_d   = wcnt_q;
      len_d    = len_q;
      first_d  = first_q;
      more_d   = more_q;
      lenblk_d = lenblk_q;
      pad_d    = pad_q;
      block_d  = block_q;
      init_d   = 1'b0;
      next_d   = 1'b0;
      done_d   = 1'b0;

      if (clear_i) begin
         state_d  = S_IDLE;
         buf_d    = '0;
         wcnt_d   = '0;
         len_d    = '0;
         first_d  = 1'b1;
         more_d   = 1'b0;
         lenblk_d = 1'b0;
         pad_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_FILL;
            S_FILL: begin
               if (in_valid_i) begin
                  wcnt_d = wcnt_q + WCNT_W'(1);
                  len_d  = len_acc;
                  if (!in_last_i) begin
                     buf_d[~wcnt_q[3:0]] = word_in;
                     if (wcnt_q == WCNT_W'(15)) begin
                        more_d   = 1'b1;
                        lenblk_d = 1'b0;
                        pad_d    = 1'b0;
                        state_d  = S_ISSUE;
                     end
                  end else begin
                     for (int i = 0; i < int'(NWORDS); i++) begin
                        if (WCNT_W'(i) == wcnt_q) begin
                           buf_d[4'(int'(NWORDS) - 1 - i)] = last_word;
                        end else if (WCNT_W'(i) > wcnt_q) begin
                           buf_d[4'(int'(NWORDS) - 1 - i)] =
                              (pad4 && (WCNT_W'(i) == wcnt_q + WCNT_W'(1))) ? 32'h8000_0000 : 32'h0;
                        end
                     end
                     if (used <= USED_W'(14)) begin
                        buf_d[1] = len_ext_acc[63:32];
                        buf_d[0] = len_ext_acc[31:0];
                        more_d   = 1'b0;
                        lenblk_d = 1'b0;
                        pad_d    = 1'b0;
                     end else begin
                        // 0x80 still owed only when the data filled word 15 exactly
                        more_d   = 1'b1;
                        lenblk_d = 1'b1;
                        pad_d    = pad4 && (wcnt_q == WCNT_W'(15));
                     end
                     state_d = S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (core_ready_i) begin
                  block_d = buf_q;
                  init_d  = first_q;
                  next_d  = !first_q;
                  first_d = 1'b0;
                  state_d = S_HOLD;
               end
            end
            S_HOLD: state_d = S_WAIT;
            S_WAIT: begin
               if (core_ready_i) begin
                  wcnt_d = '0;
                  if (more_q) begin
                     state_d = lenblk_q ? S_LENBLK : S_FILL;
                  end else begin
                     done_d  = 1'b1;
                     len_d   = '0;
                     first_d = 1'b1;
                     state_d = S_FILL;
                  end
               end
            end
            S_LENBLK: begin
               buf_d     = '0;
               buf_d[15] = pad_q ? 32'h8000_0000 : 32'h0;
               buf_d[1]  = len_ext_q[63:32];
               buf_d[0]  = len_ext_q[31:0];
               more_d    = 1'b0;
               lenblk_d  = 1'b0;
               pad_d     = 1'b0;
               state_d   = S_ISSUE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      in_ready_d = (state_d == S_FILL);
      busy_d     = !((state_d == S_IDLE) ||
                     ((state_d == S_FILL) && (wcnt_d == '0) && first_d));
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         buf_q      <= '0;
         wcnt_q     <= '0;
         len_q      <= '0;
         first_q    <= 1'b1;
         more_q     <= 1'b0;
         lenblk_q   <= 1'b0;
         pad_q      <= 1'b0;
         block_q    <= '0;
         init_q     <= 1'b0;
         next_q     <= 1'b0;
         done_q     <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         wcnt_q     <= wcnt_d;
         len_q      <= len_d;
         first_q    <= first_d;
         more_q     <= more_d;
         lenblk_q   <= lenblk_d;
         pad_q      <= pad_d;
         block_q    <= block_d;
         init_q     <= init_d;
         next_q     <= next_d;
         done_q     <= done_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign in_ready_o   = in_ready_q;
   assign core_init_o  = init_q;
   assign core_next_o  = next_q;
   assign core_block_o = block_q;
   assign done_o       = done_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: hand-computed padded blocks,
// backpressure, reset in WAIT and clear during FILL.
module tb_sha256_msg_padder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear_i;
   logic         in_valid;
   logic         in_ready_o;
   logic [31:0]  in_data;
   logic         in_last;
   logic [2:0]   in_bytes;
   logic         core_ready;
   logic         core_init_o;
   logic         core_next_o;
   logic [511:0] core_block_o;
   logic         done_o;
   logic         busy_o;

   int total = 0;
   int bad   = 0;

   // recorded by the monitor only
   logic [511:0] blk_arr [0:63];
   logic         kind_arr[0:63];
   int           nblk     = 0;
   int           done_cnt = 0;

   // read side, used by the stimulus only
   int rd        = 0;
   int done_base = 0;

   always #5 clk = ~clk;

   sha256_msg_padder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (clear_i),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready_o),
      .in_data_i    (in_data),
      .in_last_i    (in_last),
      .in_bytes_i   (in_bytes),
      .core_ready_i (core_ready),
      .core_init_o  (core_init_o),
      .core_next_o  (core_next_o),
      .core_block_o (core_block_o),
      .done_o       (done_o),
      .busy_o       (busy_o)
   );

   // Capture every issued block and done pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if ((core_init_o || core_next_o) && nblk < 64) begin
            blk_arr[nblk]  <= core_block_o;
            kind_arr[nblk] <= core_init_o;
            nblk           <= nblk + 1;
         end
         if (done_o) done_cnt <= done_cnt + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] put(input logic [511:0] e, input int i, input logic [31:0] v);
      logic [511:0] r;
      r = e;
      r[511 - 32*i -: 32] = v;
      return r;
   endfunction

   function automatic logic [31:0] pw(input int i);
      return {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
   endfunction

   task automatic send(input logic [31:0] d, input logic l, input logic [2:0] b);
      int t;
      t        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      in_bytes = b;
      while (!in_ready_o && t < 200) begin
         tick();
         t++;
      end
      total++;
      assert (t < 200) else begin
         bad++;
         $error("FAIL send_timeout observed=%0d expected<200", t);
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int t;
      t = 0;
      while (done_cnt <= done_base && t < 300) begin
         tick();
         t++;
      end
      total++;
      assert (done_cnt > done_base) else begin
         bad++;
         $error("FAIL %s_done observed=%0d expected=%0d", tag, done_cnt, done_base + 1);
      end
      done_base = done_cnt;
   endtask

   task automatic expect_blk(input string tag, input logic kinit, input logic [511:0] e);
      if (rd < nblk) begin
         chk({tag, "_kind"}, 512'(kind_arr[rd]), 512'(kinit));
         chk(tag, blk_arr[rd], e);
      end else begin
         total++;
         bad++;
         $error("FAIL %s_missing observed=%0d expected=%0d", tag, nblk, rd + 1);
      end
      rd++;
   endtask

   initial begin
      logic [511:0] e;
      logic [511:0] e2;
      logic [511:0] abc_blk;
      int           viol;
      int           t;

      rst_n      = 1'b0;
      clear_i    = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      in_bytes   = '0;
      core_ready = 1'b1;
      repeat (3) tick();

      chk("rst_in_ready", 512'(in_ready_o), 512'(0));
      chk("rst_init",     512'(core_init_o), 512'(0));
      chk("rst_next",     512'(core_next_o), 512'(0));
      chk("rst_block",    core_block_o, 512'(0));
      chk("rst_done",     512'(done_o), 512'(0));
      chk("rst_busy",     512'(busy_o), 512'(0));

      rst_n = 1'b1;
      repeat (2) tick();
      chk("idle_in_ready", 512'(in_ready_o), 512'(1));
      chk("idle_busy",     512'(busy_o), 512'(0));

      // "abc"
      abc_blk = put(512'(32'h18), 0, 32'h6162_6380);
      send(32'h6162_6300, 1'b1, 3'd3);
      wait_done("abc");
      expect_blk("abc", 1'b1, abc_blk);
      chk("abc_busy_after", 512'(busy_o), 512'(0));

      // empty message
      send(32'hDEAD_BEEF, 1'b1, 3'd0);
      wait_done("empty");
      expect_blk("empty", 1'b1, put(512'(0), 0, 32'h8000_0000));

      // "hi" with junk in the unused low bytes
      send(32'h6869_FFFF, 1'b1, 3'd2);
      wait_done("hi");
      expect_blk("hi", 1'b1, put(512'(32'h10), 0, 32'h6869_8000));

      // "hello"
      send(32'h6865_6C6C, 1'b0, 3'd4);
      send(32'h6F00_0000, 1'b1, 3'd1);
      wait_done("hello");
      e = put(512'(32'h28), 0, 32'h6865_6C6C);
      e = put(e, 1, 32'h6F80_0000);
      expect_blk("hello", 1'b1, e);

      // 56-byte message: 0x80 in word 14, length in a second block
      e = '0;
      for (int i = 0; i < 14; i++) begin
         send(pw(i), (i == 13), 3'd4);
         e = put(e, i, pw(i));
      end
      e = put(e, 14, 32'h8000_0000);
      wait_done("m56");
      expect_blk("m56_b0", 1'b1, e);
      expect_blk("m56_b1", 1'b0, 512'(32'h1C0));

      // 59-byte message: partial word 14 forces the length block without 0x80
      e = '0;
      for (int i = 0; i < 15; i++) begin
         send(pw(i), (i == 14), (i == 14) ? 3'd3 : 3'd4);
         e = put(e, i, (i == 14) ? {pw(i)[31:8], 8'h80} : pw(i));
      end
      wait_done("m59");
      expect_blk("m59_b0", 1'b1, e);
      expect_blk("m59_b1", 1'b0, 512'(32'h1D8));

      // 64-byte message: 0x80 carried into the length block
      e = '0;
      for (int i = 0; i < 16; i++) begin
         send(pw(i), (i == 15), 3'd4);
         e = put(e, i, pw(i));
      end
      wait_done("m64");
      expect_blk("m64_b0", 1'b1, e);
      expect_blk("m64_b1", 1'b0, put(512'(32'h200), 0, 32'h8000_0000));
      chk("count_a", 512'(nblk), 512'(rd));

      // backpressure: full block waits for the core, nothing accepted meanwhile
      core_ready = 1'b0;
      e = '0;
      for (int i = 0; i < 16; i++) begin
         send(pw(i), 1'b0, 3'd4);
         e = put(e, i, pw(i));
      end
      chk("bp_busy", 512'(busy_o), 512'(1));
      in_valid = 1'b1;
      in_data  = 32'h0BAD_0BAD;
      viol     = 0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready_o || core_init_o || core_next_o) viol++;
         tick();
      end
      in_valid = 1'b0;
      chk("bp_stall", 512'(viol), 512'(0));
      core_ready = 1'b1;
      tick();
      chk("bp_latency", 512'(core_init_o), 512'(1));
      send(32'hAABB_CCDD, 1'b1, 3'd1);
      wait_done("bp");
      expect_blk("bp_b0", 1'b1, e);
      expect_blk("bp_b1", 1'b0, put(512'(32'h208), 0, 32'hAA80_0000));

      // reset while waiting for the core
      send(32'h6162_6300, 1'b1, 3'd3);
      t = 0;
      while (!core_init_o && t < 50) begin
         tick();
         t++;
      end
      chk("rw_pulse_seen", 512'(core_init_o), 512'(1));
      core_ready = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("rw_in_ready", 512'(in_ready_o), 512'(0));
      chk("rw_init",     512'(core_init_o), 512'(0));
      chk("rw_block",    core_block_o, 512'(0));
      chk("rw_busy",     512'(busy_o), 512'(0));
      chk("rw_done",     512'(done_o), 512'(0));
      rd         = nblk;
      done_base  = done_cnt;
      core_ready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      send(32'h6162_6300, 1'b1, 3'd3);
      wait_done("rw_abc");
      expect_blk("rw_abc", 1'b1, abc_blk);

      // clear in the middle of a fill, word offered with clear is dropped
      for (int i = 0; i < 3; i++) send(pw(i), 1'b0, 3'd4);
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      clear_i  = 1'b1;
      tick();
      clear_i  = 1'b0;
      in_valid = 1'b0;
      chk("clr_in_ready", 512'(in_ready_o), 512'(0));
      chk("clr_busy",     512'(busy_o), 512'(0));
      tick();
      send(32'h6162_6300, 1'b1, 3'd3);
      wait_done("clr_abc");
      expect_blk("clr_abc", 1'b1, abc_blk);
      repeat (5) tick();
      chk("count_end", 512'(nblk), 512'(rd));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
